// File: rtl/reg_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_wb_queue                                                 |
// | Description : In-order write-back queue for the 32x32 register file.       |
// |               Accepts ALU and load results, queues them in a circular      |
// |               buffer and drives one registered write per cycle onto the    |
// |               file's write port. Also answers a combinational pending-     |
// |               write query for decode-stage RAW hazard handling.            |
// | Config macro: REG_WB_FORWARD_EN                                            |
// |               defined   -> chk_data carries the youngest matching data     |
// |               undefined -> chk_data tied to 0, chk_hit acts as stall req   |
// | Ports       : clk, reset       clock / synchronous active-high reset       |
// |               alu_*            ALU result offer (valid/reg/data/ready)     |
// |               mem_*            load result offer (valid/reg/data/ready)    |
// |               wb_hold          freeze draining                             |
// |               write_reg, data_write, reg_write  register-file write port   |
// |               chk_reg, chk_hit, chk_data        pending-write query        |
// |               count            occupied entries                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module reg_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_reg,
   input  logic [DATA_W-1:0]        alu_data,
   output logic                     alu_ready,
   input  logic                     mem_valid,
   input  logic [ADDR_W-1:0]        mem_reg,
   input  logic [DATA_W-1:0]        mem_data,
   output logic                     mem_ready,
   input  logic                     wb_hold,
   output logic [ADDR_W-1:0]        write_reg,
   output logic [DATA_W-1:0]        data_write,
   output logic                     reg_write,
   input  logic [ADDR_W-1:0]        chk_reg,
   output logic                     chk_hit,
   output logic [DATA_W-1:0]        chk_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = $clog2(DEPTH) + 1;

   localparam logic [c_cnt_w-1:0] c_depth_m1 = c_cnt_w'(DEPTH - 1);
   localparam logic [c_cnt_w-1:0] c_depth_m2 = c_cnt_w'(DEPTH - 2);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0]  ent_reg_q  [DEPTH];
   logic [ADDR_W-1:0]  ent_reg_d  [DEPTH];
   logic [DATA_W-1:0]  ent_data_q [DEPTH];
   logic [DATA_W-1:0]  ent_data_d [DEPTH];

   logic [c_ptr_w-1:0] head_q, head_d;
   logic [c_ptr_w-1:0] tail_q, tail_d;
   logic [c_cnt_w-1:0] count_q, count_d;

   logic               reg_write_q, reg_write_d;
   logic [ADDR_W-1:0]  write_reg_q, write_reg_d;
   logic [DATA_W-1:0]  data_write_q, data_write_d;

   // ------------------------------------------------------------------
   // Handshake and queue control
   // ------------------------------------------------------------------
   logic               mem_acc, alu_acc;
   logic               mem_store, alu_store;
   logic               pop;
   logic [c_ptr_w-1:0] alu_slot;

   // Readiness looks only at the registered count; a slot freed by this
   // cycle's pop is not offered until the next cycle. When a load is also
   // offered, the ALU needs room for two entries since the load goes first.
   assign mem_ready = (count_q <= c_depth_m1);
   assign alu_ready = mem_valid ? (count_q <= c_depth_m2)
                                : (count_q <= c_depth_m1);

   assign mem_acc   = mem_valid & mem_ready;
   assign alu_acc   = alu_valid & alu_ready;

   // Register 0 is hard-wired zero: the handshake completes but nothing is
   // stored, so such a result never reaches the write port or the query.
   assign mem_store = mem_acc & (mem_reg != '0);
   assign alu_store = alu_acc & (alu_reg != '0);

   assign pop       = (count_q != '0) & ~wb_hold;

   always_comb begin
      ent_reg_d    = ent_reg_q;
      ent_data_d   = ent_data_q;
      head_d       = head_q;
      tail_d       = tail_q;
      alu_slot     = tail_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      data_write_d = data_write_q;

      // Load result is older than a same-cycle ALU result.
      if (mem_store) begin
         ent_reg_d[tail_q]  = mem_reg;
         ent_data_d[tail_q] = mem_data;
         alu_slot           = tail_q + c_ptr_one;
      end

      if (alu_store) begin
         ent_reg_d[alu_slot]  = alu_reg;
         ent_data_d[alu_slot] = alu_data;
         tail_d               = alu_slot + c_ptr_one;
      end else begin
         tail_d               = alu_slot;
      end

      // Drain reads the stored head only; the write port is registered so
      // it stays stable through the register file's negedge write.
      if (pop) begin
         reg_write_d  = 1'b1;
         write_reg_d  = ent_reg_q[head_q];
         data_write_d = ent_data_q[head_q];
         head_d       = head_q + c_ptr_one;
      end

      count_d = count_q
              + (mem_store ? c_cnt_one : '0)
              + (alu_store ? c_cnt_one : '0)
              - (pop       ? c_cnt_one : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_reg_q[i]  <= '0;
            ent_data_q[i] <= '0;
         end
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         data_write_q <= '0;
      end else begin
         ent_reg_q    <= ent_reg_d;
         ent_data_q   <= ent_data_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         data_write_q <= data_write_d;
      end
   end

   // ------------------------------------------------------------------
   // Pending-write query
   // ------------------------------------------------------------------
   // Candidates are scanned oldest to youngest so the last match wins:
   // the output register (already popped, so the oldest) first, then the
   // stored entries from head onwards.
   logic               hit;
   logic [c_ptr_w-1:0] scan_idx;
`ifdef REG_WB_FORWARD_EN
   logic [DATA_W-1:0]  fwd_data;
`endif

   always_comb begin
      hit      = 1'b0;
      scan_idx = head_q;
`ifdef REG_WB_FORWARD_EN
      fwd_data = '0;
`endif
      if (reg_write_q && (write_reg_q == chk_reg)) begin
         hit = 1'b1;
`ifdef REG_WB_FORWARD_EN
         fwd_data = data_write_q;
`endif
      end
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + c_ptr_w'(i);
         if ((i < int'(count_q)) && (ent_reg_q[scan_idx] == chk_reg)) begin
            hit = 1'b1;
`ifdef REG_WB_FORWARD_EN
            fwd_data = ent_data_q[scan_idx];
`endif
         end
      end
      // Register 0 never carries a pending write.
      if (chk_reg == '0) begin
         hit = 1'b0;
      end
   end

   assign chk_hit = hit;
`ifdef REG_WB_FORWARD_EN
   assign chk_data = fwd_data;
`else
   assign chk_data = '0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign reg_write  = reg_write_q;
   assign write_reg  = write_reg_q;
   assign data_write = data_write_q;
   assign count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_wb_queue                                              |
// | Description : Self-checking bench for reg_wb_queue. Directed steps in one  |
// |               initial block; expected register-file writes are queued as   |
// |               results are offered and popped by a negedge write monitor.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_reg_wb_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CW     = $clog2(DEPTH) + 1;

`ifdef REG_WB_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              alu_valid = 1'b0;
   logic [ADDR_W-1:0] alu_reg = '0;
   logic [DATA_W-1:0] alu_data = '0;
   logic              alu_ready;
   logic              mem_valid = 1'b0;
   logic [ADDR_W-1:0] mem_reg = '0;
   logic [DATA_W-1:0] mem_data = '0;
   logic              mem_ready;
   logic              wb_hold = 1'b0;
   logic [ADDR_W-1:0] write_reg;
   logic [DATA_W-1:0] data_write;
   logic              reg_write;
   logic [ADDR_W-1:0] chk_reg = '0;
   logic              chk_hit;
   logic [DATA_W-1:0] chk_data;
   logic [CW-1:0]     count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] r;
      logic [DATA_W-1:0] d;
   } wb_t;

   wb_t exp_q[$];

   always #5 clk = ~clk;

   reg_wb_queue #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_reg    (alu_reg),
      .alu_data   (alu_data),
      .alu_ready  (alu_ready),
      .mem_valid  (mem_valid),
      .mem_reg    (mem_reg),
      .mem_data   (mem_data),
      .mem_ready  (mem_ready),
      .wb_hold    (wb_hold),
      .write_reg  (write_reg),
      .data_write (data_write),
      .reg_write  (reg_write),
      .chk_reg    (chk_reg),
      .chk_hit    (chk_hit),
      .chk_data   (chk_data),
      .count      (count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
      wb_t e;
      e.r = r;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Every write pulse seen on the port must match the oldest expected one.
   always @(negedge clk) begin : mon
      wb_t e;
      if (reg_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", reg_write, 1'b0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_entry", {write_reg, data_write}, e);
         end
      end
   end

   initial begin : timeout
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // ---------------- reset ----------------
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_write_reg", write_reg, 0);
      chk("rst_data_write", data_write, 0);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_mem_ready", mem_ready, 1);

      // ---------------- single ALU write ----------------
      alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h1234;
      #1;
      chk("single_alu_ready", alu_ready, 1);
      push_exp(5'd5, 32'h1234);
      tick();
      alu_valid = 1'b0;
      chk("single_count1", count, 1);
      chk("single_no_write_yet", reg_write, 0);
      tick();
      chk("single_pulse", reg_write, 1);
      chk("single_write_reg", write_reg, 5);
      chk("single_data_write", data_write, 32'h1234);
      chk("single_count0", count, 0);
      tick();
      chk("single_pulse_end", reg_write, 0);
      chk("single_hold_reg", write_reg, 5);

      // ---------------- simultaneous mem + ALU ----------------
      mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'hAAAA;
      alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'hBBBB;
      #1;
      chk("dual_mem_ready", mem_ready, 1);
      chk("dual_alu_ready", alu_ready, 1);
      push_exp(5'd3, 32'hAAAA);
      push_exp(5'd4, 32'hBBBB);
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0;
      chk("dual_count2", count, 2);
      tick();
      chk("dual_first_reg", write_reg, 3);
      tick();
      chk("dual_second_reg", write_reg, 4);
      chk("dual_second_pulse", reg_write, 1);
      tick();
      chk("dual_done", reg_write, 0);

      // ---------------- hold and fill to DEPTH ----------------
      wb_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            // count = DEPTH-1: a concurrent load leaves no room for the ALU
            mem_valid = 1'b1; mem_reg = 5'd0;
            #1;
            chk("fill_alu_ready_memv", alu_ready, 0);
            chk("fill_mem_ready_3", mem_ready, 1);
            mem_valid = 1'b0;
         end
         alu_valid = 1'b1; alu_reg = ADDR_W'(10 + i); alu_data = 32'h100 + i;
         #1;
         chk("fill_alu_ready", alu_ready, 1);
         push_exp(ADDR_W'(10 + i), 32'h100 + i);
         tick();
      end
      alu_valid = 1'b0;
      chk("full_count", count, 4);
      chk("full_alu_ready", alu_ready, 0);
      chk("full_mem_ready", mem_ready, 0);
      chk("full_no_write", reg_write, 0);
      // offered while full: must be refused
      alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'hDEAD;
      tick();
      alu_valid = 1'b0;
      chk("full_refused", count, 4);

      // release: four writes in order
      wb_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("drain_pulse", reg_write, 1);
         chk("drain_count", count, CW'(3 - i));
      end

      // refill of four with concurrent drain: count steady at 1
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_reg = ADDR_W'(14 + i); alu_data = 32'h200 + i;
         push_exp(ADDR_W'(14 + i), 32'h200 + i);
         tick();
         chk("refill_count", count, 1);
      end
      alu_valid = 1'b0;
      tick();
      chk("refill_last_reg", write_reg, 17);
      chk("refill_drained", count, 0);
      tick();
      chk("refill_idle", reg_write, 0);

      // ---------------- register 0 ----------------
      alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hFFFF;
      #1;
      chk("r0_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      chk("r0_count", count, 0);
      tick();
      chk("r0_no_pulse", reg_write, 0);
      // load to $0 together with a real ALU result
      mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h5555;
      alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
      push_exp(5'd9, 32'h99);
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0;
      chk("r0_mix_count", count, 1);
      tick();
      chk("r0_mix_reg", write_reg, 9);
      tick();

      // ---------------- hazard query ----------------
      wb_hold = 1'b1;
      alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 32'h1;
      push_exp(5'd7, 32'h1);
      tick();
      alu_data = 32'h2;
      push_exp(5'd7, 32'h2);
      tick();
      alu_valid = 1'b0;
      chk_reg = 5'd7;
      #1;
      chk("haz_hit", chk_hit, 1);
      chk("haz_data", chk_data, FWD_ON ? 32'h2 : 32'h0);
      chk_reg = 5'd0;
      #1;
      chk("haz_r0", chk_hit, 0);
      chk_reg = 5'd8;
      #1;
      chk("haz_miss", chk_hit, 0);
      chk_reg = 5'd7;
      wb_hold = 1'b0;
      tick();
      chk("haz_mixed_hit", chk_hit, 1);
      chk("haz_mixed_data", chk_data, FWD_ON ? 32'h2 : 32'h0);
      tick();
      chk("haz_outreg_hit", chk_hit, 1);
      chk("haz_outreg_data", chk_data, FWD_ON ? 32'h2 : 32'h0);
      tick();
      chk("haz_gone", chk_hit, 0);

      // ---------------- reset with entries queued ----------------
      wb_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_reg = ADDR_W'(20 + i); alu_data = 32'h300 + i;
         tick();
      end
      alu_valid = 1'b0;
      chk("mid_count3", count, 3);
      reset = 1'b1;
      wb_hold = 1'b0;
      tick();
      chk("mid_rst_count", count, 0);
      chk("mid_rst_reg_write", reg_write, 0);
      chk("mid_rst_write_reg", write_reg, 0);
      chk("mid_rst_data_write", data_write, 0);
      reset = 1'b0;
      tick();
      tick();
      chk("mid_after_count", count, 0);
      chk("mid_after_write", reg_write, 0);
      chk_reg = 5'd20;
      #1;
      chk("mid_after_hit", chk_hit, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
